skid_pipe_stage: RTL and testbench

//  Two-entry valid/ready register stage that hands data from a producer pipeline stage to a

---
 rtl/skid_pipe_stage_pkg.sv | 30 +++
 rtl/skid_pipe_stage_pipe_reg_en.sv | 30 +++
 rtl/skid_pipe_stage.sv | 129 ++++++++++++
 tb/tb_skid_pipe_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/skid_pipe_stage_pkg.sv
// Shared definitions for valid/ready pipeline stages: state encoding and handshake helpers.
package skid_pipe_stage_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned DEF_WIDTH = 8;

  // Stage occupancy doubles as the state encoding; 2'd3 is never legal.
  typedef enum logic [STATE_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // One side of a valid/ready handshake.
  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  // A beat moves across an interface when both sides agree.
  function automatic logic hs_fire(input hs_t hs);
    return hs.valid & hs.ready;
  endfunction

  // Number of entries held for a given state.
  function automatic logic [STATE_W-1:0] occ_of(input state_t st);
    return STATE_W'(st);
  endfunction

endpackage

// File: rtl/skid_pipe_stage_pipe_reg_en.sv
// Payload register with load enable, async active-low reset and synchronous clear.
module pipe_reg_en
  import skid_pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Clear wins over load so a flush always leaves the register at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/skid_pipe_stage.sv
// Two-entry valid/ready skid stage with a fully registered upstream ready.
module skid_pipe_stage
  import skid_pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [STATE_W-1:0] occupancy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;

  hs_t              w_in_hs;
  hs_t              w_out_hs;
  logic             w_accept;
  logic             w_send;

  logic             w_main_en;
  logic             w_main_from_skid;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_in_hs  = '{valid: in_valid,    ready: r_in_ready};
  assign w_out_hs = '{valid: r_out_valid, ready: out_ready};
  assign w_accept = hs_fire(w_in_hs);
  assign w_send   = hs_fire(w_out_hs);

  // Main refills from the skid entry when draining FULL, otherwise straight from the producer.
  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  // Next-state and register-load decode; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_en        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_en        = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_BUSY;
          w_main_en   = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_accept && !w_send) begin
          w_state_nxt = ST_FULL;
          w_skid_en   = 1'b1;
        end else if (w_accept && w_send) begin
          w_state_nxt = ST_BUSY;
          w_main_en   = 1'b1;
        end else if (w_send) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_send) begin
          w_state_nxt      = ST_BUSY;
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    if (flush) begin
      w_state_nxt      = ST_EMPTY;
      w_main_en        = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_en        = 1'b0;
    end
  end

  // State plus registered ready/valid, both derived from the next state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  pipe_reg_en #(
    .WIDTH (WIDTH)
  ) u_main (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_en    (w_main_en),
    .i_clr   (flush),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_reg_en #(
    .WIDTH (WIDTH)
  ) u_skid (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_en    (w_skid_en),
    .i_clr   (flush),
    .i_d     (in_data),
    .o_q     (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = occ_of(r_state);

endmodule

// File: tb/tb_skid_pipe_stage.sv
// Directed and random checks of skid_pipe_stage against a queue-based reference.
module tb_skid_pipe_stage;

  localparam int unsigned WIDTH = 8;

  logic             CLK;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  skid_pipe_stage #(.WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of at most two beats; ready reflects room after the edge.
  logic [WIDTH-1:0] m_q[$];
  bit               m_rdy = 1'b1;

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_rdy = 1'b1;
    end else begin
      bit acc;
      bit snd;
      acc = in_valid && m_rdy;
      snd = (m_q.size() > 0) && out_ready;
      if (flush) begin
        m_q.delete();
      end else begin
        if (snd) void'(m_q.pop_front());
        if (acc) m_q.push_back(in_data);
      end
      m_rdy = (m_q.size() < 2);
    end
  end

  // Per-cycle comparison against the reference, plus hold-under-stall check.
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  always @(negedge CLK) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else if (cmp_en) begin
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("in_ready",  32'(in_ready),  32'(m_rdy));
      if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
      if (prev_stall && out_valid) chk("stall_hold", 32'(out_data), 32'(prev_data));
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic lit(input string tag, input logic v, input logic [WIDTH-1:0] d,
                     input logic [1:0] occ, input logic rdy);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
    chk({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_rdy",   32'(in_ready),  32'd1);

    @(negedge CLK);
    #2;
    reset  = 1'b1;
    cmp_en = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    push(8'h11); lit("s1", 1'b1, 8'h11, 2'd1, 1'b1);
    push(8'h22); lit("s2", 1'b1, 8'h22, 2'd1, 1'b1);
    push(8'h33); lit("s3", 1'b1, 8'h33, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();      lit("s4", 1'b0, 8'h00, 2'd0, 1'b1);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    push(8'hA1); lit("b1", 1'b1, 8'hA1, 2'd1, 1'b1);
    push(8'hA2); lit("b2", 1'b1, 8'hA1, 2'd2, 1'b0);
    in_valid  = 1'b0;
    tick();      lit("b3", 1'b1, 8'hA1, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();      lit("b4", 1'b1, 8'hA2, 2'd1, 1'b1);
    tick();      lit("b5", 1'b0, 8'h00, 2'd0, 1'b1);

    // Accept and send in the same cycle
    out_ready = 1'b0;
    push(8'h05); lit("c1", 1'b1, 8'h05, 2'd1, 1'b1);
    out_ready = 1'b1;
    push(8'h06); lit("c2", 1'b1, 8'h06, 2'd1, 1'b1);
    in_valid  = 1'b0;
    tick();      lit("c3", 1'b0, 8'h00, 2'd0, 1'b1);

    // Flush from FULL discards held and incoming beats
    out_ready = 1'b0;
    push(8'hB0);
    push(8'hB1); lit("f1", 1'b1, 8'hB0, 2'd2, 1'b0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hB2;
    tick();
    lit("f2", 1'b0, 8'h00, 2'd0, 1'b1);
    chk("f2_data", 32'(out_data), 32'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();      lit("f3", 1'b0, 8'h00, 2'd0, 1'b1);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    push(8'hC0);
    push(8'hC1); lit("r1", 1'b1, 8'hC0, 2'd2, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #2;
    chk("r2_valid", 32'(out_valid), 32'd0);
    chk("r2_data",  32'(out_data),  32'd0);
    chk("r2_occ",   32'(occupancy), 32'd0);
    chk("r2_rdy",   32'(in_ready),  32'd1);
    @(negedge CLK);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    push(8'h7E); lit("r3", 1'b1, 8'h7E, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();      lit("r4", 1'b0, 8'h00, 2'd0, 1'b1);

    // Random traffic with alternating back-pressure regimes and rare flushes
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      if (((i / 700) % 2) == 0) out_ready = 1'($urandom_range(0, 3) != 0);
      else                      out_ready = 1'($urandom_range(0, 3) == 0);
      flush     = 1'($urandom_range(0, 127) == 0);
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("drain_occ", 32'(occupancy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
